// File: rtl/msrv_32_pc_sequencer_if.sv
// Fetch-side bus of the MSRV32 PC sequencer: resolving-branch inputs in, fetch address/request out.
// The sequencer takes the master modport; the fetch/branch environment takes the slave modport.
interface msrv_32_pc_sequencer_if;
    logic        branch_taken_in;
    logic [4:0]  opcode_6_to_2_in;
    logic [31:0] target_addr_in;
    logic        stall_in;
    logic        imem_ready_in;
    logic        trap_taken_in;
    logic [31:0] trap_addr_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic        imem_req_out;
    logic        flush_out;
    logic        misaligned_instr_out;
    logic [31:0] branch_cnt_out;
    logic [31:0] taken_cnt_out;

    modport master (
        input  branch_taken_in, opcode_6_to_2_in, target_addr_in, stall_in,
               imem_ready_in, trap_taken_in, trap_addr_in,
        output pc_out, pc_plus_4_out, imem_req_out, flush_out,
               misaligned_instr_out, branch_cnt_out, taken_cnt_out
    );

    modport slave (
        output branch_taken_in, opcode_6_to_2_in, target_addr_in, stall_in,
               imem_ready_in, trap_taken_in, trap_addr_in,
        input  pc_out, pc_plus_4_out, imem_req_out, flush_out,
               misaligned_instr_out, branch_cnt_out, taken_cnt_out
    );
endinterface

// File: rtl/msrv_32_pc_sequencer.sv
// MSRV32 fetch PC sequencer: turns resolved branches/traps into PC redirects with a one-cycle flush.
// Optional branch statistics counters are built when MSRV32_BRANCH_STATS_EN is defined.
module msrv_32_pc_sequencer #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    msrv_32_pc_sequencer_if.master      bus
);

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_WAIT,
        ST_FLUSH
    } state_t;

    state_t      state;
    logic [31:0] pc_reg;
    logic        req_reg;
    logic        flush_reg;
    logic        mis_reg;
    logic        pending;
    logic [31:0] pend_target;

    logic        is_ctrl;
    logic        redirect;
    logic [31:0] eff_target;
    logic        apply_any;
    logic [31:0] apply_target;
    logic [31:0] step_pc;
    logic        hold;
    logic        active;

    always_comb begin
        is_ctrl      = (bus.opcode_6_to_2_in == OP_BRANCH) ||
                       (bus.opcode_6_to_2_in == OP_JAL)    ||
                       (bus.opcode_6_to_2_in == OP_JALR);
        redirect     = bus.branch_taken_in && is_ctrl;
        eff_target   = bus.target_addr_in;
        if (bus.opcode_6_to_2_in == OP_JALR) begin
            eff_target = bus.target_addr_in & ~32'd1;
        end
        // A live redirect supersedes anything still pending.
        apply_any    = redirect || pending;
        apply_target = redirect ? eff_target : pend_target;
        step_pc      = pc_reg + 32'(PC_STEP);
        hold         = bus.stall_in || !bus.imem_ready_in;
        active       = (state == ST_RUN) || (state == ST_FLUSH);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_BOOT;
            pc_reg      <= BOOT_ADDR;
            req_reg     <= 1'b0;
            flush_reg   <= 1'b0;
            mis_reg     <= 1'b0;
            pending     <= 1'b0;
            pend_target <= '0;
        end else begin
            flush_reg <= 1'b0;
            mis_reg   <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state   <= ST_RUN;
                    req_reg <= 1'b1;
                end
                default: begin
                    req_reg <= 1'b1;
                    if (bus.trap_taken_in) begin
                        pc_reg    <= bus.trap_addr_in & ~32'd3;
                        flush_reg <= 1'b1;
                        pending   <= 1'b0;
                        state     <= ST_FLUSH;
                    end else if (hold) begin
                        if (redirect) begin
                            pending     <= 1'b1;
                            pend_target <= eff_target;
                        end
                        // A stall alone keeps the current state; an imem wait parks in WAIT.
                        if (!bus.stall_in) begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        pending <= 1'b0;
                        if (apply_any && !apply_target[1]) begin
                            pc_reg    <= apply_target;
                            flush_reg <= 1'b1;
                            state     <= ST_FLUSH;
                        end else begin
                            pc_reg  <= step_pc;
                            mis_reg <= apply_any;
                            state   <= ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

`ifdef MSRV32_BRANCH_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (active && !bus.trap_taken_in && !hold && is_ctrl) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (redirect && !eff_target[1]) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end

    assign bus.branch_cnt_out = branch_cnt;
    assign bus.taken_cnt_out  = taken_cnt;
`else
    assign bus.branch_cnt_out = '0;
    assign bus.taken_cnt_out  = '0;
`endif

    assign bus.pc_out               = pc_reg;
    assign bus.pc_plus_4_out        = step_pc;
    assign bus.imem_req_out         = req_reg;
    assign bus.flush_out            = flush_reg;
    assign bus.misaligned_instr_out = mis_reg;

endmodule
